// File: rtl/interrupt_request_unit_if.sv
// Interrupt request bus between the control unit (master) and the interrupt request unit (slave).
interface interrupt_request_unit_if #(
  parameter int unsigned NUM_MI = 14
);
  logic              NMI;
  logic [NUM_MI-1:0] MI;
  logic [NUM_MI-1:0] MICLR;
  logic              GIE;
  logic              NMIEN;
  logic              INTACK;
  logic              RSTREQ;
  logic              INTREQ;
  logic [15:0]       VECADDR;
  logic [NUM_MI-1:0] MIPEND;

  modport master (
    output NMI, MI, MICLR, GIE, NMIEN, INTACK,
    input  RSTREQ, INTREQ, VECADDR, MIPEND
  );

  modport slave (
    input  NMI, MI, MICLR, GIE, NMIEN, INTACK,
    output RSTREQ, INTREQ, VECADDR, MIPEND
  );
endinterface

// File: rtl/interrupt_request_unit.sv
// Interrupt request unit: latches NMI / maskable interrupt edges, resolves priority
// and presents a reset or interrupt request plus the vector address to CAR latch control.
module interrupt_request_unit #(
  parameter int unsigned       NUM_MI     = 14,
  parameter logic [15:0]       VEC_TOP    = 16'hFFFE,
  parameter int unsigned       RST_CYCLES = 2,
  parameter logic [NUM_MI-1:0] AUTOCLR    = '1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    PUC,
  interrupt_request_unit_if.slave irq
);

  localparam int unsigned IW = (NUM_MI > 1) ? $clog2(NUM_MI) : 1;
  localparam int unsigned CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RESET,
    S_IDLE,
    S_REQ
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     rst_cnt;

  logic              nmi_q;
  logic              nmi_pend;
  logic              nmi_armed;
  logic [NUM_MI-1:0] mi_q;
  logic [NUM_MI-1:0] mi_pend;

  logic              win_nmi;
  logic [IW-1:0]     win_idx;
  logic [15:0]       vecaddr;

  logic              reset_any;
  logic              nmi_edge;
  logic [NUM_MI-1:0] mi_edge;
  logic              nmi_take;
  logic              mi_take;
  logic              accept;
  logic              ack;
  logic              nmi_ack;
  logic [NUM_MI-1:0] mi_ack_clr;
  logic [IW-1:0]     sel_idx;
  logic [15:0]       sel_vec;

  // Request qualification and acknowledge decode
  always_comb begin
    reset_any  = rst | PUC;
    nmi_edge   = irq.NMI & ~nmi_q;
    mi_edge    = irq.MI & ~mi_q;
    nmi_take   = nmi_pend & nmi_armed;
    mi_take    = (|mi_pend) & irq.GIE;
    accept     = nmi_take | mi_take;
    ack        = (state == S_REQ) & irq.INTACK;
    nmi_ack    = ack & win_nmi;
    mi_ack_clr = (ack & ~win_nmi) ? ((NUM_MI'(1) << win_idx) & AUTOCLR) : '0;
  end

  // Maskable priority encoder: lowest pending index wins
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = NUM_MI; i > 0; i--) begin
      if (mi_pend[i-1]) sel_idx = IW'(i - 1);
    end
    sel_vec = nmi_take ? (VEC_TOP - 16'd2) : (VEC_TOP - 16'd4 - (16'(sel_idx) << 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset_any) state <= S_RESET;
    else           state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_RESET: if (rst_cnt == CW'(RST_CYCLES - 1)) state_nx = S_IDLE;
      S_IDLE:  if (accept) state_nx = S_REQ;
      S_REQ:   if (irq.INTACK || (!win_nmi && !irq.GIE)) state_nx = S_IDLE;
      default: state_nx = S_RESET;
    endcase
  end

  // Output decode
  always_comb begin
    irq.RSTREQ = (state == S_RESET);
    irq.INTREQ = (state == S_REQ);
  end

  // Reset hold counter
  always_ff @(posedge clk) begin
    if (reset_any)               rst_cnt <= '0;
    else if (state == S_RESET)   rst_cnt <= rst_cnt + CW'(1);
  end

  // Edge detectors and pending flags; a new edge wins over any clear in the same cycle
  always_ff @(posedge clk) begin
    nmi_q <= irq.NMI;
    mi_q  <= irq.MI;
    if (reset_any) begin
      nmi_pend  <= 1'b0;
      nmi_armed <= 1'b1;
      mi_pend   <= '0;
    end else begin
      nmi_pend  <= nmi_edge | (nmi_pend & ~nmi_ack);
      nmi_armed <= ~nmi_ack & (nmi_armed | irq.NMIEN);
      mi_pend   <= mi_edge | (mi_pend & ~irq.MICLR & ~mi_ack_clr);
    end
  end

  // Winner and vector latch; frozen outside the IDLE accept edge
  always_ff @(posedge clk) begin
    if (reset_any) begin
      win_nmi <= 1'b0;
      win_idx <= '0;
      vecaddr <= VEC_TOP;
    end else if ((state == S_IDLE) && accept) begin
      win_nmi <= nmi_take;
      win_idx <= sel_idx;
      vecaddr <= sel_vec;
    end
  end

  assign irq.VECADDR = vecaddr;
  assign irq.MIPEND  = mi_pend;

endmodule
